// File: rtl/johnson_decoder.sv
// Receive-side decoder and sequence checker for a 4-bit Johnson counter bus.
// Tracks lock on the legal 8-state walk, counts sequence errors and flags ring wrap.
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [3:0] LOCK_THR = 4'(LOCK_CNT);

  state_t     state, state_nx;
  logic [2:0] prev_idx, prev_idx_nx;
  logic       prev_valid, prev_valid_nx;
  logic [2:0] run_cnt, run_cnt_nx;
  logic [2:0] idx_nx;
  logic       idx_valid_nx, err_nx, wrap_nx, cnt_inc;
  logic [2:0] pop;
  logic [2:0] code_idx;
  logic       legal;
  logic [2:0] next_of_prev;

  // Decode: MSB set counts ones directly, MSB clear counts down from 8.
  always_comb begin
    pop = 3'(code_in[0]) + 3'(code_in[1]) + 3'(code_in[2]) + 3'(code_in[3]);
    if (code_in == '0)
      code_idx = 3'd0;
    else if (code_in[3])
      code_idx = pop;
    else
      code_idx = 3'(4'd8 - {1'b0, pop});
    case (code_in)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= UNLOCKED;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    prev_idx_nx   = prev_idx;
    prev_valid_nx = prev_valid;
    run_cnt_nx    = run_cnt;
    idx_nx        = idx;
    idx_valid_nx  = 1'b0;
    err_nx        = 1'b0;
    wrap_nx       = 1'b0;
    cnt_inc       = 1'b0;
    next_of_prev  = 3'(prev_idx + 3'd1);
    if (code_valid) begin
      if (!legal) begin
        err_nx     = 1'b1;
        cnt_inc    = 1'b1;
        run_cnt_nx = 3'd0;
        state_nx   = UNLOCKED;
      end else begin
        idx_nx        = code_idx;
        idx_valid_nx  = 1'b1;
        prev_idx_nx   = code_idx;
        prev_valid_nx = 1'b1;
        case (state)
          UNLOCKED: begin
            // The first legal sample after reset only seeds prev_idx.
            if (prev_valid && code_idx == next_of_prev) begin
              if (({1'b0, run_cnt} + 4'd1) >= LOCK_THR) begin
                state_nx   = LOCKED;
                run_cnt_nx = 3'd0;
              end else begin
                run_cnt_nx = 3'(run_cnt + 3'd1);
              end
            end else if (!(prev_valid && code_idx == prev_idx)) begin
              run_cnt_nx = 3'd0;
            end
          end
          LOCKED: begin
            if (code_idx == prev_idx) begin
              state_nx = LOCKED;
            end else if (code_idx == next_of_prev) begin
              wrap_nx = (prev_idx == 3'd7);
            end else begin
              err_nx     = 1'b1;
              cnt_inc    = 1'b1;
              run_cnt_nx = 3'd0;
              state_nx   = UNLOCKED;
            end
          end
          default: state_nx = UNLOCKED;
        endcase
      end
    end
  end

  // locked mirrors the state register, so it follows a lock decision by one cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      prev_idx   <= 3'd0;
      prev_valid <= 1'b0;
      run_cnt    <= 3'd0;
      idx        <= 3'd0;
      idx_valid  <= 1'b0;
      err        <= 1'b0;
      wrap       <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prev_idx   <= prev_idx_nx;
      prev_valid <= prev_valid_nx;
      run_cnt    <= run_cnt_nx;
      idx        <= idx_nx;
      idx_valid  <= idx_valid_nx;
      err        <= err_nx;
      wrap       <= wrap_nx;
      locked     <= (state == LOCKED);
      if (cnt_inc && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed scenarios plus randomized
// traffic compared against a table-driven reference model.
module tb_johnson_decoder;

  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [3:0]       code_in = 4'b0000;
  logic             code_valid = 1'b0;
  logic [2:0]       idx;
  logic             idx_valid, locked, err, wrap;
  logic [ERR_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] legal_tab [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

  // Reference model state.
  int m_idx, m_prev, m_run, m_errcnt;
  bit m_idx_valid, m_err, m_wrap, m_prev_valid, m_lockstate, m_locked_out;

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err),
    .wrap(wrap), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (legal_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [3:0] c);
    int k;
    if (r) begin
      m_idx = 0; m_prev = 0; m_run = 0; m_errcnt = 0;
      m_idx_valid = 0; m_err = 0; m_wrap = 0; m_prev_valid = 0;
      m_lockstate = 0; m_locked_out = 0;
      return;
    end
    m_locked_out = m_lockstate;
    m_idx_valid = 0; m_err = 0; m_wrap = 0;
    if (!v) return;
    k = lookup(c);
    if (k < 0) begin
      m_err = 1; m_run = 0; m_lockstate = 0;
      if (m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
      return;
    end
    m_idx = k; m_idx_valid = 1;
    if (m_lockstate) begin
      if (k == m_prev) begin
      end else if (k == (m_prev + 1) % 8) begin
        m_wrap = (m_prev == 7);
      end else begin
        m_err = 1; m_run = 0; m_lockstate = 0;
        if (m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
      end
    end else begin
      if (m_prev_valid && k == (m_prev + 1) % 8) begin
        m_run++;
        if (m_run >= LOCK_CNT) begin m_lockstate = 1; m_run = 0; end
      end else if (!(m_prev_valid && k == m_prev)) begin
        m_run = 0;
      end
    end
    m_prev = k; m_prev_valid = 1;
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit r, input bit v, input logic [3:0] c);
    @(negedge clk);
    rst_n = r; code_valid = v; code_in = c;
    @(posedge clk);
    #1;
    model_step(r, v, c);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_idx got=%0d want=0", idx); end
    n_cmp++; if (idx_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_idx_valid got=%0d want=0", idx_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_locked got=%0d want=0", locked); end
    n_cmp++; if (err !== 1'b0 || wrap !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_wrap got=%0d%0d want=00", err, wrap); end
    n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("[TB] FAIL reset_err_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_lock_acquire;
    logic [3:0] seq [3] = '{4'b0000, 4'b1000, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, seq[i]);
      n_cmp++; if (idx !== 3'(i) || idx_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL acq_idx got=%0d/%0d want=%0d/1", idx, idx_valid, i); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL acq_err got=%0d want=0", err); end
    end
    cycle(1'b0, 1'b0, 4'b1100);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL acq_locked got=%0d want=1", locked); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL acq_err_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_wrap;
    logic [3:0] seq [6] = '{4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    int exp_idx [6] = '{3, 4, 5, 6, 7, 0};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, seq[i]);
      n_cmp++; if (idx !== 3'(exp_idx[i]) || idx_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL wrap_idx got=%0d want=%0d", idx, exp_idx[i]); end
      n_cmp++; if (wrap !== (i == 5)) begin n_bad++; $display("[TB] FAIL wrap_flag step=%0d got=%0d want=%0d", i, wrap, i == 5); end
      n_cmp++; if (locked !== 1'b1 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_locked got=%0d err=%0d want=1/0", locked, err); end
    end
  endtask

  task automatic test_skip;
    cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 4'b1100);
    cycle(1'b0, 1'b1, 4'b1110);
    cycle(1'b0, 1'b1, 4'b0111);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL skip_err got=%0d want=1", err); end
    n_cmp++; if (idx !== 3'd5 || idx_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL skip_idx got=%0d/%0d want=5/1", idx, idx_valid); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL skip_err_cnt got=%0d want=1", err_cnt); end
    cycle(1'b0, 1'b0, 4'b0111);
    n_cmp++; if (err !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("[TB] FAIL skip_unlock got err=%0d locked=%0d want=0/0", err, locked); end
    cycle(1'b0, 1'b1, 4'b0011);
    cycle(1'b0, 1'b1, 4'b0001);
    cycle(1'b0, 1'b0, 4'b0001);
    n_cmp++; if (locked !== 1'b1 || idx !== 3'd7) begin n_bad++; $display("[TB] FAIL skip_relock got locked=%0d idx=%0d want=1/7", locked, idx); end
  endtask

  task automatic test_illegal;
    cycle(1'b0, 1'b1, 4'b0101);
    n_cmp++; if (err !== 1'b1 || idx_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ill_err got=%0d/%0d want=1/0", err, idx_valid); end
    n_cmp++; if (idx !== 3'd7) begin n_bad++; $display("[TB] FAIL ill_idx_held got=%0d want=7", idx); end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("[TB] FAIL ill_err_cnt got=%0d want=2", err_cnt); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'b0101);
      n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd2 || locked !== 1'b0) begin n_bad++; $display("[TB] FAIL ill_novalid got err=%0d cnt=%0d locked=%0d want=0/2/0", err, err_cnt, locked); end
    end
  endtask

  task automatic test_hold;
    cycle(1'b0, 1'b1, 4'b0000);
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_unlocked_wrap got=%0d want=0", wrap); end
    cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 4'b1100);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'(i % 2), 4'b1100);
      n_cmp++; if (idx !== 3'd2 || err !== 1'b0 || locked !== 1'b1) begin n_bad++; $display("[TB] FAIL hold got idx=%0d err=%0d locked=%0d want=2/0/1", idx, err, locked); end
      n_cmp++; if (idx_valid !== 1'(i % 2)) begin n_bad++; $display("[TB] FAIL hold_idx_valid got=%0d want=%0d", idx_valid, i % 2); end
    end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("[TB] FAIL hold_err_cnt got=%0d want=2", err_cnt); end
  endtask

  task automatic test_random;
    bit r, v, prev_lockstate;
    logic [3:0] c;
    int sel;
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 65)      c = legal_tab[(m_prev + 1) % 8];
      else if (sel < 78) c = legal_tab[m_prev];
      else if (sel < 90) c = legal_tab[$urandom_range(0, 7)];
      else               c = 4'($urandom_range(0, 15));
      v = ($urandom_range(0, 99) < 80);
      r = ($urandom_range(0, 99) < 2);
      prev_lockstate = m_lockstate;
      cycle(r, v, c);
      n_cmp++; if (idx !== 3'(m_idx) || idx_valid !== m_idx_valid) begin n_bad++; $display("[TB] FAIL rnd_idx n=%0d got=%0d/%0d want=%0d/%0d", n, idx, idx_valid, m_idx, m_idx_valid); end
      n_cmp++; if (err !== m_err || wrap !== m_wrap) begin n_bad++; $display("[TB] FAIL rnd_err_wrap n=%0d got=%0d%0d want=%0d%0d", n, err, wrap, m_err, m_wrap); end
      n_cmp++; if (err_cnt !== ERR_W'(m_errcnt)) begin n_bad++; $display("[TB] FAIL rnd_err_cnt n=%0d got=%0d want=%0d", n, err_cnt, m_errcnt); end
      if (!r && prev_lockstate == m_lockstate && m_locked_out == m_lockstate) begin
        n_cmp++; if (locked !== m_lockstate) begin n_bad++; $display("[TB] FAIL rnd_locked n=%0d got=%0d want=%0d", n, locked, m_lockstate); end
      end
    end
  endtask

  task automatic test_saturate_and_reset;
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 4'b1001);
    n_cmp++; if (err_cnt !== 8'd255 || err !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_err_cnt got=%0d err=%0d want=255/1", err_cnt, err); end
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 4'b1100);
    cycle(1'b0, 1'b0, 4'b1100);
    n_cmp++; if (locked !== 1'b1 || err_cnt !== 8'd255) begin n_bad++; $display("[TB] FAIL sat_relock got locked=%0d cnt=%0d want=1/255", locked, err_cnt); end
    cycle(1'b1, 1'b1, 4'b1110);
    n_cmp++; if (idx !== 3'd0 || idx_valid !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_lock got idx=%0d iv=%0d locked=%0d want=0/0/0", idx, idx_valid, locked); end
    n_cmp++; if (err !== 1'b0 || wrap !== 1'b0 || err_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL rst_flags got err=%0d wrap=%0d cnt=%0d want=0/0/0", err, wrap, err_cnt); end
    cycle(1'b0, 1'b0, 4'b1110);
    n_cmp++; if (locked !== 1'b0 || idx_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_after got locked=%0d iv=%0d want=0/0", locked, idx_valid); end
  endtask

  initial begin
    $display("[TB] starting johnson_decoder bench");
    test_reset;
    test_lock_acquire;
    test_wrap;
    test_skip;
    test_illegal;
    test_hold;
    test_random;
    test_saturate_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive-side checker and decoder for a 4-bit Johnson (twisted-ring) counter bus.
- Converts each sampled code to a binary state index.
- Verifies the code walks the legal 8-state sequence and acquires and loses lock.
- Counts sequence errors and flags ring wrap-around, so downstream logic can use the counter as a phase/tick source.

Parameters:
- WIDTH, 4, Johnson register width. Fixed at 4 for this revision: 8 states, 3-bit index.
- LOCK_CNT, 2, consecutive in-sequence advances required to enter LOCKED (1..7).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset. Active-HIGH despite the name: 1 = reset on the next rising clk edge.
- code_in  input  WIDTH  Johnson code from the counter.
- code_valid  input  1  qualifies code_in. Ignored when 0.
- idx  output  3  decoded state index of the last legal sample.
- idx_valid  output  1  1-cycle pulse when idx is updated.
- locked  output  1  level: decoder is tracking a legal sequence.
- err  output  1  1-cycle pulse on an illegal code or sequence violation.
- wrap  output  1  1-cycle pulse on an index 7 -> 0 advance while LOCKED.
- err_cnt  output  ERR_W  saturating count of err pulses.

Behaviour:
- Legal sequence (shift-right, complemented LSB fed back to MSB): 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7, then back to 0000.
- Decode rule: code 0000 gives 0. If code[3]=1, idx = popcount. Otherwise idx = 8 - popcount.
- Legality: the code must be one of the 8 values above. The other 8 four-bit values (e.g. 0101, 1001, 0100, 1011) are illegal.
- Sampling: all decisions are made only on cycles with code_valid=1. Every output is registered, with 1-cycle latency from the sampling edge to idx/idx_valid/err/wrap/locked/err_cnt.
- Registers: prev_idx (3b), run_cnt (3b), FSM state.
- FSM UNLOCKED (reset state):
  - Illegal code: err=1, err_cnt++, run_cnt=0, idx unchanged, idx_valid=0.
  - Legal code: idx loaded, idx_valid=1.
  - If prev is valid and the code is (prev_idx+1) mod 8: run_cnt++.
  - If the code equals prev_idx: run_cnt is held.
  - Otherwise: run_cnt=0. No err is raised in UNLOCKED for a skip.
  - When run_cnt reaches LOCK_CNT: go to LOCKED; locked=1 from the following cycle.
- FSM LOCKED:
  - Code equals prev_idx (counter paused): no change, idx_valid=1, no err.
  - Code equals prev_idx+1 mod 8: advance, idx_valid=1. If prev_idx=7, wrap=1.
  - Any other legal code (skip/backwards), or any illegal code: err=1, err_cnt++, go to UNLOCKED, run_cnt=0, locked=0 next cycle.
  - On a legal-but-out-of-sequence code, idx is still loaded with it and idx_valid=1. On an illegal code, idx is held.
- wrap is never asserted in UNLOCKED, including on the advance that causes lock acquisition.
- err_cnt saturates at all-ones and does not wrap.
- Reset (rst_n=1 at an edge), at any time including mid-lock: idx=0, idx_valid=0, locked=0, err=0, wrap=0, err_cnt=0, run_cnt=0, state=UNLOCKED, prev marked invalid. Reset has priority over code_valid on the same edge.
- The first legal sample after reset only seeds prev_idx and does not count toward run_cnt.

Test Plan:
- Reset then code_valid=1 stream 0000,1000,1100 -> idx 0,1,2 with idx_valid each cycle; locked=1 one cycle after the 1100 result (LOCK_CNT=2); err=0; err_cnt=0.
- Locked; continue 1110,1111,0111,0011,0001,0000 -> idx 3..7 then 0; wrap=1 only on the 0001->0000 result; locked stays 1.
- Locked at idx 3 (1110); drive 0111 (idx 5, skip) -> err=1 for 1 cycle, err_cnt=1, idx=5, locked=0. Then 0011,0001 -> relock after 2 advances.
- Locked; drive illegal 0101 -> err=1, idx held, locked=0, err_cnt increments; same code repeated with code_valid=0 -> no further err.
- Locked at 1100 (idx 2); hold 1100 for 5 samples, with code_valid toggling -> no err, locked stays 1, idx=2.
- Force 300 illegal samples with ERR_W=8 -> err_cnt stops at 255. Assert rst_n=1 for one edge while locked -> all outputs 0 next cycle, locked=0.
